// File: rtl/r_id_allocator.sv
// Maps original AXI read IDs to unique {row,col} IDs for the read-reorder path.
// One row per distinct in-flight ID; columns hand out in order and are freed by the R ordering unit.
module r_id_allocator #(
  parameter int ID_WIDTH        = 32,
  parameter int MAX_OUTSTANDING = 16,
  parameter int NUM_ROWS        = MAX_OUTSTANDING,
  parameter int NUM_COLS        = MAX_OUTSTANDING
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [ID_WIDTH-1:0] alloc_orig_id,
  output logic [ID_WIDTH-1:0] alloc_uid,
  input  logic                allocator_free_req,
  input  logic [ID_WIDTH-1:0] uid_to_restore,
  output logic [ID_WIDTH-1:0] restored_id
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [COL_W:0] CNT_FULL = (COL_W+1)'(NUM_COLS);

  logic                row_valid_q [NUM_ROWS];
  logic                row_valid_d [NUM_ROWS];
  logic [ID_WIDTH-1:0] row_id_q    [NUM_ROWS];
  logic [ID_WIDTH-1:0] row_id_d    [NUM_ROWS];
  logic [COL_W-1:0]    ptr_q       [NUM_ROWS];
  logic [COL_W-1:0]    ptr_d       [NUM_ROWS];
  logic [COL_W:0]      cnt_q       [NUM_ROWS];
  logic [COL_W:0]      cnt_d       [NUM_ROWS];

  logic             hit;
  logic             any_free;
  logic [ROW_W-1:0] hit_row;
  logic [ROW_W-1:0] free_row;
  logic [ROW_W-1:0] sel_row;
  logic [ROW_W-1:0] rel_row;
  logic             ready_raw;
  logic             fire;
  logic [NUM_ROWS-1:0] inc;
  logic [NUM_ROWS-1:0] dec;

  // Descending scan so the lowest-index invalid row wins.
  always_comb begin
    hit      = 1'b0;
    hit_row  = '0;
    any_free = 1'b0;
    free_row = '0;
    for (int r = NUM_ROWS-1; r >= 0; r--) begin
      if (row_valid_q[r] && row_id_q[r] == alloc_orig_id) begin
        hit     = 1'b1;
        hit_row = ROW_W'(r);
      end
      if (!row_valid_q[r]) begin
        any_free = 1'b1;
        free_row = ROW_W'(r);
      end
    end
  end

  assign sel_row   = hit ? hit_row : free_row;
  assign rel_row   = ROW_W'(uid_to_restore >> COL_W);
  assign ready_raw = hit ? (cnt_q[hit_row] != CNT_FULL) : any_free;
  assign alloc_ready = !rst && ready_raw;
  assign fire        = alloc_valid && alloc_ready;
  assign alloc_uid   = rst ? '0 : ID_WIDTH'({sel_row, ptr_q[sel_row]});
  assign restored_id = rst ? '0 : row_id_q[rel_row];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_valid_d[r] = row_valid_q[r];
      row_id_d[r]    = row_id_q[r];
      ptr_d[r]       = ptr_q[r];
      cnt_d[r]       = cnt_q[r];
      inc[r] = fire && (sel_row == ROW_W'(r));
      dec[r] = allocator_free_req && (rel_row == ROW_W'(r))
               && (cnt_q[r] != '0);
      if (inc[r]) begin
        ptr_d[r] = ptr_q[r] + 1'b1;
        if (!hit) begin
          row_valid_d[r] = 1'b1;
          row_id_d[r]    = alloc_orig_id;
        end
      end
      if (inc[r] && !dec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec[r] && !inc[r]) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
        if (cnt_q[r] == (COL_W+1)'(1)) row_valid_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_valid_q[r] <= 1'b0;
        row_id_q[r]    <= '0;
        ptr_q[r]       <= '0;
        cnt_q[r]       <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_valid_q[r] <= row_valid_d[r];
        row_id_q[r]    <= row_id_d[r];
        ptr_q[r]       <= ptr_d[r];
        cnt_q[r]       <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_r_id_allocator.sv
// Directed bench for r_id_allocator with hand-computed uids and restores.
// Inputs change at posedge+1; outputs are sampled at the following negedge.
module tb_r_id_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_orig_id;
  logic [31:0] alloc_uid;
  logic        allocator_free_req;
  logic [31:0] uid_to_restore;
  logic [31:0] restored_id;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  r_id_allocator dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_valid        (alloc_valid),
    .alloc_ready        (alloc_ready),
    .alloc_orig_id      (alloc_orig_id),
    .alloc_uid          (alloc_uid),
    .allocator_free_req (allocator_free_req),
    .uid_to_restore     (uid_to_restore),
    .restored_id        (restored_id)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drv(input logic v, input logic [31:0] id,
                     input logic fr, input logic [31:0] uid);
    alloc_valid        = v;
    alloc_orig_id      = id;
    allocator_free_req = fr;
    uid_to_restore     = uid;
    #4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b1, 32'h5, 1'b0, 32'h10);
    chk("rst_ready", {31'd0, alloc_ready}, 32'd0);
    chk("rst_uid", alloc_uid, 32'h0);
    chk("rst_restore", restored_id, 32'h0);
    step();
    rst = 1'b0;

    // 1: first allocations
    drv(1'b1, 32'h5, 1'b0, 32'h0);
    chk("t1_rdy0", {31'd0, alloc_ready}, 32'd1);
    chk("t1_uid0", alloc_uid, 32'h00);
    step();
    drv(1'b1, 32'h5, 1'b0, 32'h0);
    chk("t1_rdy1", {31'd0, alloc_ready}, 32'd1);
    chk("t1_uid1", alloc_uid, 32'h01);
    step();
    drv(1'b1, 32'h9, 1'b0, 32'h0);
    chk("t1_rdy2", {31'd0, alloc_ready}, 32'd1);
    chk("t1_uid2", alloc_uid, 32'h10);
    step();

    // 2: restore lookups
    drv(1'b0, 32'h0, 1'b0, 32'h10);
    chk("t2_r10", restored_id, 32'h9);
    drv(1'b0, 32'h0, 1'b0, 32'h01);
    chk("t2_r01", restored_id, 32'h5);
    step();

    // 3: fill row 0, stall, free one slot, column wraps
    for (int c = 2; c < 16; c++) begin
      drv(1'b1, 32'h5, 1'b0, 32'h0);
      chk("t3_fill", alloc_uid, 32'(c));
      step();
    end
    drv(1'b1, 32'h5, 1'b1, 32'h00);
    chk("t3_full", {31'd0, alloc_ready}, 32'd0);
    step();
    drv(1'b1, 32'h5, 1'b0, 32'h0);
    chk("t3_wrap_rdy", {31'd0, alloc_ready}, 32'd1);
    chk("t3_wrap_uid", alloc_uid, 32'h00);
    step();

    // 4: drain row 0 (ptr=1), reuse it for ID 0x7
    for (int c = 0; c < 16; c++) begin
      drv(1'b0, 32'h0, 1'b1, 32'(c));
      if (c == 15) chk("t4_last_restore", restored_id, 32'h5);
      step();
    end
    drv(1'b1, 32'h7, 1'b0, 32'h0);
    chk("t4_reuse_rdy", {31'd0, alloc_ready}, 32'd1);
    chk("t4_reuse_uid", alloc_uid, 32'h01);
    step();
    drv(1'b0, 32'h0, 1'b0, 32'h01);
    chk("t4_restore", restored_id, 32'h7);

    // 5: fill rows 2..15 with distinct IDs
    for (int r = 2; r < 16; r++) begin
      drv(1'b1, 32'h100 + 32'(r), 1'b0, 32'h0);
      chk("t5_fill", alloc_uid, 32'(r) << 4);
      step();
    end
    drv(1'b1, 32'hABC, 1'b0, 32'h0);
    chk("t5_stall", {31'd0, alloc_ready}, 32'd0);
    drv(1'b1, 32'h9, 1'b0, 32'h0);
    chk("t5_hit_rdy", {31'd0, alloc_ready}, 32'd1);
    chk("t5_hit_uid", alloc_uid, 32'h11);
    step();
    drv(1'b1, 32'hABC, 1'b1, 32'h20);
    chk("t5_free_same", {31'd0, alloc_ready}, 32'd0);
    step();
    drv(1'b1, 32'hABC, 1'b0, 32'h0);
    chk("t5_free_next", {31'd0, alloc_ready}, 32'd1);
    chk("t5_free_uid", alloc_uid, 32'h21);
    step();

    // 6: alloc and free of row 0's last slot together
    drv(1'b1, 32'h7, 1'b1, 32'h01);
    chk("t6_same_uid", alloc_uid, 32'h02);
    step();
    drv(1'b1, 32'hDEAD, 1'b0, 32'h00);
    chk("t6_still_valid", {31'd0, alloc_ready}, 32'd0);
    chk("t6_restore", restored_id, 32'h7);
    drv(1'b0, 32'h0, 1'b1, 32'h02);
    step();
    drv(1'b1, 32'hDEAD, 1'b0, 32'h00);
    chk("t6_cnt1_rdy", {31'd0, alloc_ready}, 32'd1);
    chk("t6_cnt1_uid", alloc_uid, 32'h03);
    step();

    // reset mid-stream
    rst = 1'b1;
    drv(1'b1, 32'h9, 1'b0, 32'h21);
    chk("mr_ready", {31'd0, alloc_ready}, 32'd0);
    chk("mr_uid", alloc_uid, 32'h0);
    chk("mr_restore", restored_id, 32'h0);
    step();
    rst = 1'b0;
    drv(1'b1, 32'h5, 1'b0, 32'h21);
    chk("post_rst_rdy", {31'd0, alloc_ready}, 32'd1);
    chk("post_rst_uid", alloc_uid, 32'h00);
    chk("post_rst_restore", restored_id, 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
